// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like port arbiter: requester IDs, transfer sizes
// and the request-lock state.
package sram_like_arbiter_pkg;

    localparam int ID_W = 1;

    localparam logic [ID_W-1:0] ID_INST = 1'b0;
    localparam logic [ID_W-1:0] ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request fields from the master, handshake and read data
// from the slave.
interface sram_like_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [3:0]    wstrb;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order queue of owner IDs for accepted-but-unreturned memory transactions.
// The caller never pushes into a full queue unless it pops in the same cycle.
module sram_like_arbiter_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  logic            pop,
    input  logic [ID_W-1:0] din,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ID_W-1:0] slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= din;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between fetch (inst) and MEM-stage (data)
// requesters, and routes in-order responses back to the owner of each request.
//
// state   | meaning
// LK_OPEN | nothing stalled on the port; data wins over inst
// LK_HELD | presented request not yet accepted; grant pinned to lock_owner
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic               clk,
    input  logic               resetn,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master mem,
    output logic               arb_err
);
    lock_state_t     state;
    lock_state_t     state_nxt;
    logic [ID_W-1:0] lock_owner;
    logic [ID_W-1:0] owner_nxt;
    logic [ID_W-1:0] grant;

    logic            g_req;
    logic            g_wr;
    logic [1:0]      g_size;
    logic [AW-1:0]   g_addr;
    logic [3:0]      g_wstrb;
    logic [DW-1:0]   g_wdata;

    logic            full;
    logic            empty;
    logic [ID_W-1:0] head;
    logic            accept;
    logic            pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= LK_OPEN;
            lock_owner <= ID_DATA;
        end else begin
            state      <= state_nxt;
            lock_owner <= owner_nxt;
        end
    end

    // A stalled request keeps the port until it is accepted or withdrawn.
    always_comb begin
        state_nxt = LK_OPEN;
        owner_nxt = lock_owner;
        if (mem.req && !mem.addr_ok) begin
            state_nxt = LK_HELD;
            owner_nxt = grant;
        end
    end

    always_comb begin
        grant = ID_INST;
        if (state == LK_HELD) grant = lock_owner;
        else if (data.req)    grant = ID_DATA;
    end

    always_comb begin
        g_req   = inst.req;
        g_wr    = inst.wr;
        g_size  = inst.size;
        g_addr  = inst.addr;
        g_wstrb = inst.wstrb;
        g_wdata = inst.wdata;
        if (grant == ID_DATA) begin
            g_req   = data.req;
            g_wr    = data.wr;
            g_size  = data.size;
            g_addr  = data.addr;
            g_wstrb = data.wstrb;
            g_wdata = data.wdata;
        end
    end

    // A full queue still accepts when a response frees the head slot this cycle.
    assign mem.req   = resetn & g_req & (~full | mem.data_ok);
    assign mem.wr    = g_wr;
    assign mem.size  = g_size;
    assign mem.addr  = g_addr;
    assign mem.wstrb = g_wstrb;
    assign mem.wdata = g_wdata;

    assign accept       = mem.req & mem.addr_ok;
    assign inst.addr_ok = accept & (grant == ID_INST);
    assign data.addr_ok = accept & (grant == ID_DATA);

    assign pop          = resetn & mem.data_ok & ~empty;
    assign inst.data_ok = pop & (head == ID_INST);
    assign data.data_ok = pop & (head == ID_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) arb_err <= 1'b0;
        else         arb_err <= mem.data_ok & empty;
    end

    sram_like_arbiter_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed scenarios plus a randomized
// run, checked against a transaction-level model of the arbiter.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int OUT = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic arb_err;

    sram_like_arbiter_if #(.AW(32), .DW(32)) inst_bus ();
    sram_like_arbiter_if #(.AW(32), .DW(32)) data_bus ();
    sram_like_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

    sram_like_arbiter #(
        .OUTSTANDING (OUT),
        .AW          (32),
        .DW          (32)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst    (inst_bus),
        .data    (data_bus),
        .mem     (mem_bus),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } resp_t;

    resp_t       sb_q[$];
    logic        m_q[$];     // owners of accepted, unreturned requests (1 = data)
    int          m_lock;     // requester pinned to the port, -1 when none
    bit          m_err;
    bit          i_pend, d_pend;
    logic [31:0] i_addr, d_addr;
    int          n_vec = 0;
    int          n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req();
        inst_bus.req   = i_pend;
        inst_bus.addr  = i_addr;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = SIZE_WORD;
        inst_bus.wstrb = 4'hf;
        inst_bus.wdata = 32'h0;
        data_bus.req   = d_pend;
        data_bus.addr  = d_addr;
        data_bus.wr    = d_addr[2];
        data_bus.size  = SIZE_WORD;
        data_bus.wstrb = 4'hf;
        data_bus.wdata = ~d_addr;
    endtask

    // One bus cycle: launch requests, drive the bridge, check at negedge, advance model.
    task automatic step(input bit li, input logic [31:0] ai, input bit ld, input logic [31:0] ad,
                        input bit aok, input bit dok, input logic [31:0] rd);
        int    pres;
        bit    preq, pop, emreq, acc;
        resp_t e;
        if (li && !i_pend) begin i_pend = 1'b1; i_addr = ai; end
        if (ld && !d_pend) begin d_pend = 1'b1; d_addr = ad; end
        drive_req();
        mem_bus.addr_ok = aok;
        mem_bus.data_ok = dok;
        mem_bus.rdata   = rd;
        if (dok && m_q.size() > 0) begin
            e.owner = m_q[0];
            e.rdata = rd;
            sb_q.push_back(e);
        end
        @(negedge clk);
        pres = m_lock;
        if (pres < 0) pres = d_pend ? 1 : (i_pend ? 0 : -1);
        preq  = (pres == 1 && d_pend) || (pres == 0 && i_pend);
        pop   = dok && m_q.size() > 0;
        emreq = preq && (m_q.size() < OUT || pop);
        acc   = emreq && aok;
        chk("mem_req", {31'b0, mem_bus.req}, {31'b0, emreq});
        if (emreq) begin
            chk("mem_addr", mem_bus.addr, (pres == 1) ? d_addr : i_addr);
            chk("mem_wdata", mem_bus.wdata, (pres == 1) ? ~d_addr : 32'h0);
            chk("mem_wr", {31'b0, mem_bus.wr}, (pres == 1) ? {31'b0, d_addr[2]} : 32'h0);
        end
        chk("inst_addr_ok", {31'b0, inst_bus.addr_ok}, {31'b0, acc && pres == 0});
        chk("data_addr_ok", {31'b0, data_bus.addr_ok}, {31'b0, acc && pres == 1});
        chk("arb_err", {31'b0, arb_err}, {31'b0, m_err});
        m_err = dok && m_q.size() == 0;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back(pres == 1);
            if (pres == 1) d_pend = 1'b0;
            else           i_pend = 1'b0;
        end
        m_lock = (emreq && !aok) ? pres : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int budget = 40;
        while ((m_q.size() > 0 || i_pend || d_pend) && budget > 0) begin
            step(0, 0, 0, 0, 1, m_q.size() > 0, $urandom);
            budget--;
        end
        chk("drain_done", {31'b0, (m_q.size() > 0 || i_pend || d_pend)}, 32'h0);
    endtask

    task automatic reset_mid();
        i_pend = 1'b1; i_addr = 32'hbfc00200;
        d_pend = 1'b1; d_addr = 32'h80000040;
        drive_req();
        mem_bus.addr_ok = 1'b1;
        mem_bus.data_ok = 1'b1;
        mem_bus.rdata   = 32'hdeadbeef;
        resetn = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_bus.req}, 32'h0);
        chk("rst_inst_addr_ok", {31'b0, inst_bus.addr_ok}, 32'h0);
        chk("rst_data_addr_ok", {31'b0, data_bus.addr_ok}, 32'h0);
        chk("rst_inst_data_ok", {31'b0, inst_bus.data_ok}, 32'h0);
        chk("rst_data_data_ok", {31'b0, data_bus.data_ok}, 32'h0);
        chk("rst_arb_err", {31'b0, arb_err}, 32'h0);
        m_q.delete();
        m_lock = -1;
        m_err  = 1'b0;
        i_pend = 1'b0;
        d_pend = 1'b0;
        @(posedge clk);
        #1;
        drive_req();
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        resetn = 1'b1;
    endtask

    // Response monitor: every negedge, the owner named by the scoreboard must see data_ok.
    always @(negedge clk) begin : monitor
        resp_t e;
        logic  ei, ed;
        ei = 1'b0;
        ed = 1'b0;
        e  = '0;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ei = (e.owner == ID_INST);
            ed = (e.owner == ID_DATA);
        end
        chk("inst_data_ok", {31'b0, inst_bus.data_ok}, {31'b0, ei});
        chk("data_data_ok", {31'b0, data_bus.data_ok}, {31'b0, ed});
        if (ei) chk("inst_rdata", inst_bus.rdata, e.rdata);
        if (ed) chk("data_rdata", data_bus.rdata, e.rdata);
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin : stim
        m_lock = -1;
        m_err  = 1'b0;
        i_pend = 1'b0; i_addr = '0;
        d_pend = 1'b0; d_addr = '0;
        drive_req();
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req", {31'b0, mem_bus.req}, 32'h0);
        chk("reset_arb_err", {31'b0, arb_err}, 32'h0);
        resetn = 1'b1;

        // single fetch
        step(1, 32'hbfc00000, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 32'h24010001);
        idle(1);

        // simultaneous requests: data first, then inst
        step(1, 32'hbfc00004, 1, 32'h80000010, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'haaaa0001);
        step(0, 0, 0, 0, 0, 1, 32'hbbbb0002);

        // stall lock: inst held while data arrives
        step(1, 32'hbfc00100, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h80000020, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        drain();

        // full queue, then accept with same-cycle push and pop
        step(1, 32'hbfc00010, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h80000030, 1, 0, 0);
        step(1, 32'hbfc00014, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h11110000);
        step(0, 0, 1, 32'h80000034, 1, 0, 0);
        drain();

        // stray response, then reset in the middle of a burst
        step(0, 0, 0, 0, 0, 1, 32'h00000005);
        idle(2);
        step(1, 32'hbfc00020, 1, 32'h80000038, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 32'hbfc00024, 0, 0, 0, 0, 0);
        reset_mid();
        step(0, 0, 0, 0, 0, 1, 32'h00000077);
        idle(2);
        step(1, 32'hbfc00030, 1, 32'h80000050, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        drain();

        // randomized traffic with random bridge latency
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 45, 32'hbfc00000 | ($urandom & 32'h00000ffc),
                 $urandom_range(0, 99) < 45, 32'h80000000 | ($urandom & 32'h00000ffc),
                 $urandom_range(0, 99) < 60,
                 (m_q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3),
                 $urandom);
        end
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
